adc_conv_sched: RTL and testbench

Conversion scheduler sharing the single ADC conversion datapath among NREQ requesters (timer triggers, DMA, software agents). Powers the converter up on demand and waits for ready. Grants one conversion at a time in round-robin order and returns the result and error status to the granted requester. Powers the converter down after a programmable idle period. Sits between the requester fabric and the ADC interface's enable/start/end-of-conversion handshake.

---
 rtl/adc_conv_sched_if.sv | 32 +++
 rtl/adc_conv_sched.sv | 181 ++++++++++++++++++
 tb/tb_adc_conv_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_conv_sched_if.sv
// Requester-fabric and ADC-handshake bundle for the conversion scheduler.
// REQ is a level held by a requester until its DONE bit pulses; GNT and DONE
// are one-cycle one-hot pulses; ADC_START/ADC_EOC form a pulse pair around
// one conversion, with ADC_DATA qualified by ADC_EOC in the same cycle.
interface adc_conv_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 12
);
  logic            EN;
  logic [NREQ-1:0] REQ;
  logic [NREQ-1:0] GNT;
  logic [NREQ-1:0] DONE;
  logic [DW-1:0]   RESULT;
  logic            ERR;
  logic            BUSY;
  logic            ADC_EN;
  logic            ADC_RDY;
  logic            ADC_START;
  logic            ADC_EOC;
  logic [DW-1:0]   ADC_DATA;
  logic [2:0]      state_dbg;

  modport slave (
    input  EN, REQ, ADC_RDY, ADC_EOC, ADC_DATA,
    output GNT, DONE, RESULT, ERR, BUSY, ADC_EN, ADC_START, state_dbg
  );

  modport master (
    output EN, REQ, ADC_RDY, ADC_EOC, ADC_DATA,
    input  GNT, DONE, RESULT, ERR, BUSY, ADC_EN, ADC_START, state_dbg
  );
endinterface

// File: rtl/adc_conv_sched.sv
// Round-robin scheduler sharing one ADC among NREQ requesters, with on-demand
// power-up, conversion/wake timeouts and idle power-down.
module adc_conv_sched #(
  parameter int NREQ         = 4,
  parameter int DW           = 12,
  parameter int CONV_TIMEOUT = 32,
  parameter int WAKE_TIMEOUT = 256,
  parameter int IDLE_OFF     = 1024
) (
  input logic             PCLK,
  input logic             PRESET,
  adc_conv_sched_if.slave bus
);
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAX_WC  = (WAKE_TIMEOUT > CONV_TIMEOUT) ? WAKE_TIMEOUT : CONV_TIMEOUT;
  localparam int CNT_MAX = (IDLE_OFF > MAX_WC) ? IDLE_OFF : MAX_WC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_TIMEOUT - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_TIMEOUT - 1);
  localparam logic [CW-1:0] IDLE_LAST = (IDLE_OFF > 0) ? CW'(IDLE_OFF - 1) : '0;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_WAKE  = 3'd1,
    S_IDLE  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   pick;
  logic [DW-1:0]   result;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            err;
  logic            busy;
  logic            adc_en;
  logic            adc_start;

  // Rotate the request vector so the search always starts at ptr; the
  // offset of the lowest set bit is then added back modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [PW-1:0]   base);
    logic [2*NREQ-1:0] dbl;
    logic [PW-1:0]     off;
    logic [PW:0]       sum;
    logic              found;
    dbl   = {req, req} >> base;
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && dbl[0]) begin
        off   = PW'(i);
        found = 1'b1;
      end
      dbl = dbl >> 1;
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
    return sum[PW-1:0];
  endfunction

  always_comb pick = rr_pick(bus.REQ, ptr);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= S_OFF;
      cnt       <= '0;
      ptr       <= '0;
      idx       <= '0;
      result    <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      adc_en    <= 1'b0;
      adc_start <= 1'b0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      adc_start <= 1'b0;
      case (state)
        S_OFF: begin
          cnt <= '0;
          if (bus.EN && |bus.REQ) begin
            state  <= S_WAKE;
            adc_en <= 1'b1;
          end
        end
        S_WAKE: begin
          if (!bus.EN) begin
            state  <= S_OFF;
            adc_en <= 1'b0;
            cnt    <= '0;
          end else if (bus.ADC_RDY) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == WAKE_LAST) begin
            state  <= S_OFF;
            adc_en <= 1'b0;
            err    <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          // A converter that lost ready is re-woken before any new grant.
          if (!bus.EN) begin
            state  <= S_OFF;
            adc_en <= 1'b0;
            cnt    <= '0;
          end else if (!bus.ADC_RDY) begin
            state <= S_WAKE;
            cnt   <= '0;
          end else if (|bus.REQ) begin
            state     <= S_START;
            idx       <= pick;
            gnt       <= NREQ'(1) << pick;
            adc_start <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
          end else if ((IDLE_OFF != 0) && (cnt == IDLE_LAST)) begin
            state  <= S_OFF;
            adc_en <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_START: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          // EOC is checked first so a result arriving in the timeout cycle wins.
          if (bus.ADC_EOC) begin
            state  <= S_DONE;
            result <= bus.ADC_DATA;
            done   <= NREQ'(1) << idx;
            cnt    <= '0;
          end else if (cnt == CONV_LAST) begin
            state <= S_DONE;
            err   <= 1'b1;
            done  <= NREQ'(1) << idx;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          ptr   <= (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
          cnt   <= '0;
        end
        default: begin
          state  <= S_OFF;
          adc_en <= 1'b0;
          busy   <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.GNT       = gnt;
  assign bus.DONE      = done;
  assign bus.RESULT    = result;
  assign bus.ERR       = err;
  assign bus.BUSY      = busy;
  assign bus.ADC_EN    = adc_en;
  assign bus.ADC_START = adc_start;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_adc_conv_sched.sv
// Directed bench for adc_conv_sched: wake, round-robin, timeouts, power-down,
// EN drop and asynchronous reset, each scenario checked cycle-exactly.
module tb_adc_conv_sched;
  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam logic [2:0] ST_OFF  = 3'd0;
  localparam logic [2:0] ST_WAKE = 3'd1;
  localparam logic [2:0] ST_IDLE = 3'd2;

  logic PCLK = 1'b0;
  logic PRESET;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   gnt_cnt = 0;
  int   done_cnt = 0;
  logic [1:0] exp_q[$];

  // ---------------- clock / reset / DUTs ----------------
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  adc_conv_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();
  adc_conv_sched_if #(.NREQ(NREQ), .DW(DW)) bus0 ();

  adc_conv_sched #(.NREQ(NREQ), .DW(DW), .CONV_TIMEOUT(32), .WAKE_TIMEOUT(256),
                   .IDLE_OFF(16)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus.slave));
  adc_conv_sched #(.NREQ(NREQ), .DW(DW), .CONV_TIMEOUT(32), .WAKE_TIMEOUT(256),
                   .IDLE_OFF(0)) dut0 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus0.slave));

  // Pulse monitor, sampled 1 time unit after the rising edge.
  always @(posedge PCLK) begin
    #1;
    if (!PRESET) begin
      if (|bus.GNT)  gnt_cnt  = gnt_cnt + 1;
      if (|bus.DONE) done_cnt = done_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic wait_gnt(output int g_idx, output bit ok);
    int n;
    n = 0; ok = 1'b0; g_idx = -1;
    while (!ok && n < 40) begin
      @(negedge PCLK);
      n++;
      if (|bus.GNT) begin
        ok = 1'b1;
        for (int b = 0; b < NREQ; b++) if (bus.GNT == (NREQ'(1) << b)) g_idx = b;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    bus.EN = 1'b0; bus.REQ = '0; bus.ADC_RDY = 1'b0; bus.ADC_EOC = 1'b0; bus.ADC_DATA = '0;
    tick(2);
    PRESET = 1'b0;
    tick(1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.GNT, bus.DONE, bus.ERR, bus.BUSY, bus.ADC_EN, bus.ADC_START} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b done=%b err=%b busy=%b en=%b start=%b exp all 0",
               bus.GNT, bus.DONE, bus.ERR, bus.BUSY, bus.ADC_EN, bus.ADC_START);
    end
    checks++;
    if (bus.RESULT !== 12'h000 || bus.state_dbg !== ST_OFF) begin
      failures++;
      $display("FAIL reset_state: got result=%h state=%0d exp 000/OFF", bus.RESULT, bus.state_dbg);
    end
  endtask

  task automatic test_single();
    int g0, d0;
    g0 = gnt_cnt; d0 = done_cnt;
    bus.EN = 1'b1; bus.REQ = 4'b0100; bus.ADC_RDY = 1'b0;    // cycle T
    tick(1);                                                  // T+1
    checks++;
    if (bus.ADC_EN !== 1'b1 || bus.state_dbg !== ST_WAKE) begin
      failures++;
      $display("FAIL single_wake: got en=%b state=%0d exp 1/WAKE", bus.ADC_EN, bus.state_dbg);
    end
    tick(3);                                                  // T+4
    bus.ADC_RDY = 1'b1;
    tick(1);                                                  // T+5
    checks++;
    if (bus.state_dbg !== ST_IDLE || bus.GNT !== 4'b0000) begin
      failures++;
      $display("FAIL single_idle: got state=%0d gnt=%b exp IDLE/0000", bus.state_dbg, bus.GNT);
    end
    tick(1);                                                  // T+6
    checks++;
    if (bus.GNT !== 4'b0100 || bus.ADC_START !== 1'b1 || bus.BUSY !== 1'b1) begin
      failures++;
      $display("FAIL single_gnt: got gnt=%b start=%b busy=%b exp 0100/1/1",
               bus.GNT, bus.ADC_START, bus.BUSY);
    end
    tick(1);                                                  // T+7 WAIT
    checks++;
    if (bus.GNT !== 4'b0000 || bus.ADC_START !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse: got gnt=%b start=%b exp 0000/0", bus.GNT, bus.ADC_START);
    end
    bus.ADC_EOC = 1'b1; bus.ADC_DATA = 12'hA5C;
    tick(1);                                                  // T+8
    bus.ADC_EOC = 1'b0; bus.ADC_DATA = '0; bus.REQ = 4'b0000;
    checks++;
    if (bus.DONE !== 4'b0100 || bus.RESULT !== 12'hA5C || bus.ERR !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got done=%b result=%h err=%b exp 0100/a5c/0",
               bus.DONE, bus.RESULT, bus.ERR);
    end
    tick(1);                                                  // T+9 IDLE
    checks++;
    if (bus.DONE !== 4'b0000 || bus.BUSY !== 1'b0 || bus.RESULT !== 12'hA5C) begin
      failures++;
      $display("FAIL single_after: got done=%b busy=%b result=%h exp 0000/0/a5c",
               bus.DONE, bus.BUSY, bus.RESULT);
    end
    checks++;
    if (gnt_cnt - g0 !== 1 || done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL single_counts: got gnts=%0d dones=%0d exp 1/1", gnt_cnt - g0, done_cnt - d0);
    end
  endtask

  // Entered on the first IDLE cycle after a DONE, with REQ low.
  task automatic test_idle_powerdown();
    tick(15);
    checks++;
    if (bus.ADC_EN !== 1'b1 || bus.state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL idle_hold: got en=%b state=%0d exp 1/IDLE", bus.ADC_EN, bus.state_dbg);
    end
    tick(1);
    checks++;
    if (bus.ADC_EN !== 1'b0 || bus.state_dbg !== ST_OFF || bus.ERR !== 1'b0) begin
      failures++;
      $display("FAIL idle_off: got en=%b state=%0d err=%b exp 0/OFF/0",
               bus.ADC_EN, bus.state_dbg, bus.ERR);
    end
  endtask

  task automatic test_round_robin();
    int g_idx, prev;
    bit ok;
    logic [1:0] e;
    apply_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0};
    bus.EN = 1'b1; bus.ADC_RDY = 1'b1; bus.REQ = 4'b1111;
    prev = 0;
    for (int k = 0; k < 7; k++) begin
      wait_gnt(g_idx, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || g_idx !== int'(e)) begin
        failures++;
        $display("FAIL rr_order[%0d]: got idx=%0d (seen=%0b) exp %0d", k, g_idx, ok, e);
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev !== 4) begin
          failures++;
          $display("FAIL back_to_back[%0d]: got gap=%0d exp 4", k, cyc - prev);
        end
      end
      prev = cyc;
      tick(1);
      bus.ADC_EOC = 1'b1; bus.ADC_DATA = 12'h100 + 12'(k);
      if (k == 4) bus.REQ = 4'b1001;
      if (k == 6) bus.REQ = 4'b0000;
      tick(1);
      bus.ADC_EOC = 1'b0;
      checks++;
      if (bus.DONE !== (NREQ'(1) << e) || bus.RESULT !== 12'h100 + 12'(k)) begin
        failures++;
        $display("FAIL rr_done[%0d]: got done=%b result=%h exp %b/%h",
                 k, bus.DONE, bus.RESULT, NREQ'(1) << e, 12'h100 + 12'(k));
      end
    end
  endtask

  task automatic test_timeout();
    int g_idx, d0;
    bit ok;
    apply_reset();
    bus.EN = 1'b1; bus.ADC_RDY = 1'b1; bus.REQ = 4'b0001;
    wait_gnt(g_idx, ok);
    tick(1);
    bus.ADC_EOC = 1'b1; bus.ADC_DATA = 12'h3C7;
    tick(1);
    bus.ADC_EOC = 1'b0;
    checks++;
    if (bus.DONE !== 4'b0001 || bus.RESULT !== 12'h3C7) begin
      failures++;
      $display("FAIL to_prep: got done=%b result=%h exp 0001/3c7", bus.DONE, bus.RESULT);
    end
    wait_gnt(g_idx, ok);
    checks++;
    if (!ok || g_idx !== 0) begin
      failures++;
      $display("FAIL to_regrant: got idx=%0d seen=%0b exp 0", g_idx, ok);
    end
    tick(1);                                                  // W
    tick(31);                                                 // W+31
    checks++;
    if (bus.DONE !== 4'b0000 || bus.BUSY !== 1'b1) begin
      failures++;
      $display("FAIL to_early: got done=%b busy=%b exp 0000/1", bus.DONE, bus.BUSY);
    end
    tick(1);                                                  // W+32
    bus.REQ = 4'b0000;
    checks++;
    if (bus.DONE !== 4'b0001 || bus.ERR !== 1'b1 || bus.RESULT !== 12'h3C7) begin
      failures++;
      $display("FAIL to_done: got done=%b err=%b result=%h exp 0001/1/3c7",
               bus.DONE, bus.ERR, bus.RESULT);
    end
    tick(1);
    checks++;
    if (bus.ERR !== 1'b0) begin
      failures++;
      $display("FAIL to_err_pulse: got err=%b exp 0", bus.ERR);
    end
    bus.REQ = 4'b0001;
    wait_gnt(g_idx, ok);
    tick(32);                                                 // W'+31
    bus.ADC_EOC = 1'b1; bus.ADC_DATA = 12'h777;
    tick(1);                                                  // W'+32
    bus.ADC_EOC = 1'b0; bus.REQ = 4'b0000;
    checks++;
    if (bus.DONE !== 4'b0001 || bus.ERR !== 1'b0 || bus.RESULT !== 12'h777) begin
      failures++;
      $display("FAIL to_eoc_wins: got done=%b err=%b result=%h exp 0001/0/777",
               bus.DONE, bus.ERR, bus.RESULT);
    end
    tick(1);
    d0 = done_cnt;
    bus.ADC_EOC = 1'b1; bus.ADC_DATA = 12'hFFF;
    tick(1);
    bus.ADC_EOC = 1'b0;
    tick(2);
    checks++;
    if (bus.RESULT !== 12'h777 || done_cnt !== d0) begin
      failures++;
      $display("FAIL eoc_ignored: got result=%h dones=%0d exp 777/0", bus.RESULT, done_cnt - d0);
    end
  endtask

  task automatic test_wake_fail();
    int g0, d0, g_idx;
    bit ok;
    apply_reset();
    g0 = gnt_cnt; d0 = done_cnt;
    bus.EN = 1'b1; bus.ADC_RDY = 1'b0; bus.REQ = 4'b0100;     // T
    tick(256);                                                // T+256
    checks++;
    if (bus.ADC_EN !== 1'b1 || bus.ERR !== 1'b0) begin
      failures++;
      $display("FAIL wake_hold: got en=%b err=%b exp 1/0", bus.ADC_EN, bus.ERR);
    end
    tick(1);                                                  // T+257
    checks++;
    if (bus.ADC_EN !== 1'b0 || bus.ERR !== 1'b1 || bus.DONE !== 4'b0000) begin
      failures++;
      $display("FAIL wake_fail: got en=%b err=%b done=%b exp 0/1/0000",
               bus.ADC_EN, bus.ERR, bus.DONE);
    end
    tick(1);                                                  // T+258
    checks++;
    if (bus.ADC_EN !== 1'b1 || bus.ERR !== 1'b0 || bus.state_dbg !== ST_WAKE) begin
      failures++;
      $display("FAIL wake_retry: got en=%b err=%b state=%0d exp 1/0/WAKE",
               bus.ADC_EN, bus.ERR, bus.state_dbg);
    end
    checks++;
    if (gnt_cnt !== g0 || done_cnt !== d0) begin
      failures++;
      $display("FAIL wake_no_done: got gnts=%0d dones=%0d exp 0/0", gnt_cnt - g0, done_cnt - d0);
    end
    bus.ADC_RDY = 1'b1;
    wait_gnt(g_idx, ok);
    tick(1);
    bus.ADC_EOC = 1'b1; bus.ADC_DATA = 12'h0AB;
    tick(1);
    bus.ADC_EOC = 1'b0; bus.REQ = 4'b0000;
    checks++;
    if (!ok || g_idx !== 2 || bus.DONE !== 4'b0100 || bus.RESULT !== 12'h0AB) begin
      failures++;
      $display("FAIL wake_recover: got idx=%0d done=%b result=%h exp 2/0100/0ab",
               g_idx, bus.DONE, bus.RESULT);
    end
  endtask

  task automatic test_en_drop();
    int g_idx;
    bit ok;
    apply_reset();
    bus.EN = 1'b1; bus.ADC_RDY = 1'b1; bus.REQ = 4'b0010;
    wait_gnt(g_idx, ok);                                      // G
    tick(1);                                                  // G+1 WAIT
    bus.EN = 1'b0;
    tick(1);                                                  // G+2
    checks++;
    if (bus.BUSY !== 1'b1 || bus.DONE !== 4'b0000) begin
      failures++;
      $display("FAIL endrop_busy: got busy=%b done=%b exp 1/0000", bus.BUSY, bus.DONE);
    end
    bus.ADC_EOC = 1'b1; bus.ADC_DATA = 12'h5A5;
    tick(1);                                                  // G+3
    bus.ADC_EOC = 1'b0; bus.REQ = 4'b0000;
    checks++;
    if (bus.DONE !== 4'b0010 || bus.RESULT !== 12'h5A5 || bus.ADC_EN !== 1'b1) begin
      failures++;
      $display("FAIL endrop_done: got done=%b result=%h en=%b exp 0010/5a5/1",
               bus.DONE, bus.RESULT, bus.ADC_EN);
    end
    tick(1);                                                  // G+4
    checks++;
    if (bus.ADC_EN !== 1'b1 || bus.BUSY !== 1'b0) begin
      failures++;
      $display("FAIL endrop_idle: got en=%b busy=%b exp 1/0", bus.ADC_EN, bus.BUSY);
    end
    tick(1);                                                  // G+5
    checks++;
    if (bus.ADC_EN !== 1'b0 || bus.state_dbg !== ST_OFF) begin
      failures++;
      $display("FAIL endrop_off: got en=%b state=%0d exp 0/OFF", bus.ADC_EN, bus.state_dbg);
    end
  endtask

  task automatic test_preset_mid();
    int g_idx, d0;
    bit ok;
    apply_reset();
    bus.EN = 1'b1; bus.ADC_RDY = 1'b1; bus.REQ = 4'b1000;
    wait_gnt(g_idx, ok);
    tick(1);
    d0 = done_cnt;
    checks++;
    if (!ok || g_idx !== 3 || bus.BUSY !== 1'b1) begin
      failures++;
      $display("FAIL preset_setup: got idx=%0d busy=%b exp 3/1", g_idx, bus.BUSY);
    end
    PRESET = 1'b1;
    #1;
    checks++;
    if (bus.ADC_EN !== 1'b0 || bus.BUSY !== 1'b0 || bus.state_dbg !== ST_OFF) begin
      failures++;
      $display("FAIL preset_async: got en=%b busy=%b state=%0d exp 0/0/OFF",
               bus.ADC_EN, bus.BUSY, bus.state_dbg);
    end
    bus.ADC_EOC = 1'b1; bus.ADC_DATA = 12'hFFF;
    tick(2);
    bus.ADC_EOC = 1'b0; bus.EN = 1'b0; bus.REQ = 4'b0000;
    PRESET = 1'b0;
    tick(3);
    checks++;
    if ({bus.GNT, bus.DONE, bus.ERR, bus.BUSY, bus.ADC_EN, bus.ADC_START} !== '0 ||
        bus.RESULT !== 12'h000 || done_cnt !== d0) begin
      failures++;
      $display("FAIL preset_quiet: got gnt=%b done=%b err=%b en=%b result=%h dones=%0d exp all 0",
               bus.GNT, bus.DONE, bus.ERR, bus.ADC_EN, bus.RESULT, done_cnt - d0);
    end
  endtask

  task automatic test_idle_off_zero();
    int n, low;
    bit seen;
    apply_reset();
    bus0.EN = 1'b1; bus0.ADC_RDY = 1'b1; bus0.REQ = 4'b0001;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge PCLK);
      n++;
      if (bus0.GNT == 4'b0001) seen = 1'b1;
    end
    tick(1);
    bus0.ADC_EOC = 1'b1; bus0.ADC_DATA = 12'h123;
    tick(1);
    bus0.ADC_EOC = 1'b0; bus0.REQ = 4'b0000;
    checks++;
    if (!seen || bus0.DONE !== 4'b0001 || bus0.RESULT !== 12'h123) begin
      failures++;
      $display("FAIL nooff_conv: got seen=%0b done=%b result=%h exp 1/0001/123",
               seen, bus0.DONE, bus0.RESULT);
    end
    low = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge PCLK);
      if (bus0.ADC_EN !== 1'b1) low++;
    end
    checks++;
    if (low !== 0 || bus0.state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL nooff_hold: got low_cycles=%0d state=%0d exp 0/IDLE", low, bus0.state_dbg);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    PRESET = 1'b1;
    bus0.EN = 1'b0; bus0.REQ = '0; bus0.ADC_RDY = 1'b0; bus0.ADC_EOC = 1'b0; bus0.ADC_DATA = '0;
    test_reset();
    test_single();
    test_idle_powerdown();
    test_round_robin();
    test_timeout();
    test_wake_fail();
    test_en_drop();
    test_preset_mid();
    test_idle_off_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
